// File: rtl/gerador_tons_pkg.sv
// gerador_tons shared constants
// off marker, minimum half-period, clamp helper
package gerador_tons_pkg;

  localparam int LARGURA_CP = 18;
  localparam int CP_MINIMO  = 2;

  localparam logic [LARGURA_CP-1:0] CP_DESLIGADO =
    {LARGURA_CP{1'b1}};

  function automatic logic [LARGURA_CP-1:0] limita_periodo(
    input logic [LARGURA_CP-1:0] v
  );
    if (v < LARGURA_CP'(CP_MINIMO))
      return LARGURA_CP'(CP_MINIMO);
    return v;
  endfunction

endpackage

// File: rtl/oscilador_voz.sv
// one square-wave voice: counter, period latch,
// toggle and active flag, changes only at boundaries
module oscilador_voz
  import gerador_tons_pkg::*;
#(
  parameter int LARGURA = LARGURA_CP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] cp,
  output logic               onda,
  output logic               ativa
);

  logic [LARGURA-1:0] cont;
  logic [LARGURA-1:0] per_atual;
  logic [LARGURA-1:0] per_novo;
  logic               desligado;
  logic               fronteira;

  // clamp and off detection of the incoming word
  always_comb begin
    desligado = &cp;
    per_novo  = cp;
    if (cp < LARGURA'(CP_MINIMO))
      per_novo = LARGURA'(CP_MINIMO);
    fronteira = (cont == per_atual - LARGURA'(1));
  end

  // voice state: start, count, toggle or stop at boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont      <= '0;
      per_atual <= '1;
      onda      <= 1'b0;
      ativa     <= 1'b0;
    end else if (!ativa) begin
      if (!desligado) begin
        per_atual <= per_novo;
        cont      <= '0;
        onda      <= 1'b1;
        ativa     <= 1'b1;
      end else begin
        onda      <= 1'b0;
      end
    end else if (!fronteira) begin
      cont <= cont + LARGURA'(1);
    end else begin
      cont <= '0;
      if (desligado) begin
        ativa <= 1'b0;
        onda  <= 1'b0;
      end else begin
        onda      <= ~onda;
        per_atual <= per_novo;
      end
    end
  end

endmodule

// File: rtl/gerador_tons.sv
// polyphonic square-wave tone generator
// NR_TECLAS voices mixed into one signed sample
module gerador_tons #(
  parameter int NR_TECLAS       = 10,
  parameter int LARGURA_CP      = 18,
  parameter int LARGURA_AMOSTRA = 16,
  parameter int AMPLITUDE       = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NR_TECLAS-1:0][LARGURA_CP-1:0] cp,
  output logic [NR_TECLAS-1:0] onda,
  output logic [NR_TECLAS-1:0] ativas,
  output logic signed [LARGURA_AMOSTRA-1:0] amostra,
  output logic [$clog2(NR_TECLAS+1)-1:0] nr_ativas
);

  localparam int LN = $clog2(NR_TECLAS + 1);
  localparam int LA = LARGURA_AMOSTRA;

  localparam logic signed [LA-1:0] AMP =
    LA'(AMPLITUDE);

  if (longint'(NR_TECLAS) * longint'(AMPLITUDE) >
      (longint'(1) <<< (LA - 1)) - 1) begin : g_chk
    $error("gerador_tons: mix can overflow sample");
  end

  for (genvar i = 0; i < NR_TECLAS; i++) begin : g_voz
    oscilador_voz #(
      .LARGURA (LARGURA_CP)
    ) u_voz (
      .clk   (clk),
      .rst_n (rst_n),
      .cp    (cp[i]),
      .onda  (onda[i]),
      .ativa (ativas[i])
    );
  end

  logic signed [LA-1:0] soma;
  logic [LN-1:0]        conta;

  // full-width sum of active voices and their count
  always_comb begin
    soma  = '0;
    conta = '0;
    for (int i = 0; i < NR_TECLAS; i++) begin
      if (ativas[i]) begin
        soma  = onda[i] ? soma + AMP : soma - AMP;
        conta = conta + LN'(1);
      end
    end
  end

  // register the mixed sample and active count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amostra   <= '0;
      nr_ativas <= '0;
    end else begin
      amostra   <= soma;
      nr_ativas <= conta;
    end
  end

endmodule
